// File: rtl/event_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | event_sched_pkg: shared types and helpers for event_delay_scheduler   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package event_sched_pkg;

    localparam int MAX_SLOTS = 16;

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_WAIT = 2'd1,
        SLOT_DUE  = 2'd2
    } slot_state_e;

    typedef enum logic [0:0] {
        OUT_EMPTY   = 1'b0,
        OUT_PRESENT = 1'b1
    } out_state_e;

    // Index of the lowest set bit; 0 when no bit is set (callers qualify with |vec).
    function automatic int unsigned lowest_set(input logic [MAX_SLOTS-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_sched_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | event_sched_slot: one pending-event slot (state, countdown, tag)      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module event_sched_slot
    import event_sched_pkg::*;
#(
    parameter int DLY_W = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             release_slot,
    input  logic             flush,
    input  logic [DLY_W-1:0] load_delay,
    input  logic [TAG_W-1:0] load_tag,
    output logic             free,
    output logic             due,
    output logic [TAG_W-1:0] tag
);

    slot_state_e      r_state;
    logic [DLY_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_FREE;
            r_count <= '0;
            tag     <= '0;
        end else if (flush) begin
            r_state <= SLOT_FREE;
        end else if (load) begin
            r_state <= SLOT_WAIT;
            r_count <= load_delay;
            tag     <= load_tag;
        end else if (release_slot) begin
            r_state <= SLOT_FREE;
        end else if (r_state == SLOT_WAIT) begin
            if (r_count == '0) r_state <= SLOT_DUE;
            else               r_count <= r_count - 1'b1;
        end
    end

    // An expired WAIT slot already counts as due so the output stage can capture it this cycle.
    assign free = (r_state == SLOT_FREE);
    assign due  = (r_state == SLOT_DUE) || ((r_state == SLOT_WAIT) && (r_count == '0));

endmodule
`default_nettype wire

// File: rtl/event_delay_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | event_delay_scheduler: timed-event slots with ordered valid/ready out |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module event_delay_scheduler
    import event_sched_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int DLY_W = 8,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       post_valid,
    output logic                       post_ready,
    input  logic [DLY_W-1:0]           post_delay,
    input  logic [TAG_W-1:0]           post_tag,
    output logic                       fire_valid,
    input  logic                       fire_ready,
    output logic [TAG_W-1:0]           fire_tag,
    input  logic                       flush,
    output logic                       busy,
    output logic [$clog2(SLOTS+1)-1:0] pending_cnt
);

    localparam int SEL_W = $clog2(SLOTS);
    localparam int CNT_W = $clog2(SLOTS + 1);

    logic [SLOTS-1:0] w_free;
    logic [SLOTS-1:0] w_due;
    logic [SLOTS-1:0] w_load;
    logic [SLOTS-1:0] w_release;
    logic [TAG_W-1:0] w_tag [SLOTS];
    logic [SEL_W-1:0] w_alloc_idx;
    logic [SEL_W-1:0] w_due_idx;

    out_state_e       r_state;
    out_state_e       w_state_n;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_n;
    logic [TAG_W-1:0] w_fire_tag_n;

    assign w_alloc_idx = SEL_W'(lowest_set(MAX_SLOTS'(w_free)));
    assign w_due_idx   = SEL_W'(lowest_set(MAX_SLOTS'(w_due)));

    assign post_ready = (|w_free) && !flush;
    assign fire_valid = (r_state == OUT_PRESENT);
    assign busy       = !(&w_free) || (r_state == OUT_PRESENT);

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign w_load[i]    = post_valid && post_ready && (w_alloc_idx == SEL_W'(i));
        assign w_release[i] = (r_state == OUT_PRESENT) && fire_ready && !flush
                              && (r_sel == SEL_W'(i));

        event_sched_slot #(
            .DLY_W (DLY_W),
            .TAG_W (TAG_W)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .load         (w_load[i]),
            .release_slot (w_release[i]),
            .flush        (flush),
            .load_delay   (post_delay),
            .load_tag     (post_tag),
            .free         (w_free[i]),
            .due          (w_due[i]),
            .tag          (w_tag[i])
        );
    end

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!w_free[i]) pending_cnt = pending_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= OUT_EMPTY;
            r_sel    <= '0;
            fire_tag <= '0;
        end else begin
            r_state  <= w_state_n;
            r_sel    <= w_sel_n;
            fire_tag <= w_fire_tag_n;
        end
    end

    // Flush wins over both capture and acceptance.
    always_comb begin
        w_state_n    = r_state;
        w_sel_n      = r_sel;
        w_fire_tag_n = fire_tag;
        if (flush) begin
            w_state_n = OUT_EMPTY;
        end else begin
            case (r_state)
                OUT_EMPTY: begin
                    if (|w_due) begin
                        w_state_n    = OUT_PRESENT;
                        w_sel_n      = w_due_idx;
                        w_fire_tag_n = w_tag[w_due_idx];
                    end
                end
                OUT_PRESENT: begin
                    if (fire_ready) w_state_n = OUT_EMPTY;
                end
                default: w_state_n = OUT_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_event_delay_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_event_delay_scheduler: directed vectors and corner sequences       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_event_delay_scheduler;

    logic       clk;
    logic       rst_n;
    logic       post_valid;
    logic       post_ready;
    logic [7:0] post_delay;
    logic [3:0] post_tag;
    logic       fire_valid;
    logic       fire_ready;
    logic [3:0] fire_tag;
    logic       flush;
    logic       busy;
    logic [2:0] pending_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       pv;
        logic [7:0] pd;
        logic [3:0] pt;
        logic       fr;
        logic       fl;
        logic       efv;
        logic [3:0] etag;
        logic       epr;
        logic [2:0] epend;
        logic       ebusy;
    } vec_t;

    vec_t vecs[$];

    event_delay_scheduler #(
        .SLOTS (4),
        .DLY_W (8),
        .TAG_W (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .post_valid  (post_valid),
        .post_ready  (post_ready),
        .post_delay  (post_delay),
        .post_tag    (post_tag),
        .fire_valid  (fire_valid),
        .fire_ready  (fire_ready),
        .fire_tag    (fire_tag),
        .flush       (flush),
        .busy        (busy),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic pv, input logic [7:0] pd, input logic [3:0] pt,
                                input logic fr, input logic fl, input logic efv,
                                input logic [3:0] etag, input logic epr,
                                input logic [2:0] epend, input logic ebusy);
        vec_t v;
        v.pv = pv; v.pd = pd; v.pt = pt; v.fr = fr; v.fl = fl;
        v.efv = efv; v.etag = etag; v.epr = epr; v.epend = epend; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic pv, input logic [7:0] pd, input logic [3:0] pt,
                          input logic fr, input logic fl);
        post_valid = pv; post_delay = pd; post_tag = pt; fire_ready = fr; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset fire_valid", 32'(fire_valid), 32'd0);
        chk("reset fire_tag", 32'(fire_tag), 32'd0);
        chk("reset post_ready", 32'(post_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset pending_cnt", 32'(pending_cnt), 32'd0);
        next_cycle();

        // Single post: tag 5, delay 3, accepted in row 0 -> fires in row 5.
        vecs.push_back(mk(1, 8'd3, 4'h5, 1, 0,  0, 4'h0, 1, 3'd0, 0));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  1, 4'h5, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd0, 0));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd0, 0));
        // Ordering: A delay 6 at row 0, B delay 1 at row 1 -> B at row 4, A at row 8.
        vecs.push_back(mk(1, 8'd6, 4'hA, 1, 0,  0, 4'h0, 1, 3'd0, 0));
        vecs.push_back(mk(1, 8'd1, 4'hB, 1, 0,  0, 4'h0, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd2, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd2, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  1, 4'hB, 1, 3'd2, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  1, 4'hA, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd0, 0));
        // Simultaneous due: delays 2,1,0 at rows 0,1,2 all expire in row 3.
        vecs.push_back(mk(1, 8'd2, 4'h1, 1, 0,  0, 4'h0, 1, 3'd0, 0));
        vecs.push_back(mk(1, 8'd1, 4'h2, 1, 0,  0, 4'h0, 1, 3'd1, 1));
        vecs.push_back(mk(1, 8'd0, 4'h3, 1, 0,  0, 4'h0, 1, 3'd2, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd3, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  1, 4'h1, 1, 3'd3, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd2, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  1, 4'h2, 1, 3'd2, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  1, 4'h3, 1, 3'd1, 1));
        vecs.push_back(mk(0, 8'd0, 4'h0, 1, 0,  0, 4'h0, 1, 3'd0, 0));

        foreach (vecs[i]) begin
            set_in(vecs[i].pv, vecs[i].pd, vecs[i].pt, vecs[i].fr, vecs[i].fl);
            @(negedge clk);
            chk($sformatf("vec%0d fire_valid", i), 32'(fire_valid), 32'(vecs[i].efv));
            if (vecs[i].efv)
                chk($sformatf("vec%0d fire_tag", i), 32'(fire_tag), 32'(vecs[i].etag));
            chk($sformatf("vec%0d post_ready", i), 32'(post_ready), 32'(vecs[i].epr));
            chk($sformatf("vec%0d pending_cnt", i), 32'(pending_cnt), 32'(vecs[i].epend));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].ebusy));
            next_cycle();
        end

        // Full slots under backpressure.
        set_in(1, 8'd0, 4'h1, 0, 0); @(negedge clk); chk("full post0 ready", 32'(post_ready), 32'd1); next_cycle();
        set_in(1, 8'd5, 4'h2, 0, 0); @(negedge clk); chk("full post1 ready", 32'(post_ready), 32'd1); next_cycle();
        set_in(1, 8'd5, 4'h3, 0, 0); @(negedge clk); chk("full post2 ready", 32'(post_ready), 32'd1); next_cycle();
        set_in(1, 8'd5, 4'h4, 0, 0); @(negedge clk); chk("full post3 ready", 32'(post_ready), 32'd1); next_cycle();
        set_in(1, 8'd5, 4'h9, 0, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d post_ready", k), 32'(post_ready), 32'd0);
            chk($sformatf("hold%0d fire_valid", k), 32'(fire_valid), 32'd1);
            chk($sformatf("hold%0d fire_tag", k), 32'(fire_tag), 32'h1);
            chk($sformatf("hold%0d pending_cnt", k), 32'(pending_cnt), 32'd4);
            next_cycle();
        end
        set_in(0, 8'd0, 4'h0, 1, 0);
        @(negedge clk);
        chk("accept fire_valid", 32'(fire_valid), 32'd1);
        next_cycle();
        set_in(0, 8'd0, 4'h0, 0, 0);
        @(negedge clk);
        chk("freed post_ready", 32'(post_ready), 32'd1);
        chk("freed fire_valid bubble", 32'(fire_valid), 32'd0);
        chk("freed pending_cnt", 32'(pending_cnt), 32'd3);
        next_cycle();
        @(negedge clk);
        chk("next fire_valid", 32'(fire_valid), 32'd1);
        chk("next fire_tag", 32'(fire_tag), 32'h2);
        next_cycle();

        // Flush with a post and an accept in the same cycle.
        set_in(1, 8'd0, 4'h9, 1, 1);
        @(negedge clk);
        chk("flush post_ready", 32'(post_ready), 32'd0);
        next_cycle();
        set_in(0, 8'd0, 4'h0, 0, 0);
        @(negedge clk);
        chk("after flush pending_cnt", 32'(pending_cnt), 32'd0);
        chk("after flush busy", 32'(busy), 32'd0);
        chk("after flush fire_valid", 32'(fire_valid), 32'd0);
        chk("after flush post_ready", 32'(post_ready), 32'd1);
        next_cycle();
        set_in(0, 8'd0, 4'h0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("post flush%0d fire_valid", k), 32'(fire_valid), 32'd0);
            next_cycle();
        end

        // Asynchronous reset with events pending and one presented.
        set_in(1, 8'd3, 4'h7, 0, 0); next_cycle();
        set_in(1, 8'd0, 4'h8, 0, 0); next_cycle();
        set_in(0, 8'd0, 4'h0, 0, 0); next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("pre reset fire_valid", 32'(fire_valid), 32'd1);
        chk("pre reset fire_tag", 32'(fire_tag), 32'h8);
        chk("pre reset pending_cnt", 32'(pending_cnt), 32'd2);
        next_cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("async fire_valid", 32'(fire_valid), 32'd0);
        chk("async fire_tag", 32'(fire_tag), 32'd0);
        chk("async post_ready", 32'(post_ready), 32'd1);
        chk("async busy", 32'(busy), 32'd0);
        chk("async pending_cnt", 32'(pending_cnt), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        set_in(0, 8'd0, 4'h0, 1, 0);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            chk($sformatf("post reset%0d fire_valid", k), 32'(fire_valid), 32'd0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
